// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider for RV32M div/divu/rem/remu with RISC-V edge-case semantics
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] res_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W:0]      rem;
  logic [W-1:0]    quo, dvs;
  logic            is_rem, neg;
  logic            sa, sb, div0, ovf;
  logic [W-1:0]    mag_a, mag_b, res_sel, res_next;
  logic [W:0]      shifted;
  logic [W+1:0]    trial;
  always_comb begin
    sa       = !op_i[0] && a_i[W-1];
    sb       = !op_i[0] && b_i[W-1];
    mag_a    = sa ? -a_i : a_i;
    mag_b    = sb ? -b_i : b_i;
    div0     = b_i == '0;
    ovf      = !op_i[0] && a_i == {1'b1, {(W-1){1'b0}}} && b_i == '1;
    shifted  = {rem[W-1:0], quo[W-1]};
    // one extra bit so a negative trial is visible in the MSB
    trial    = {1'b0, shifted} - {2'b0, dvs};
    res_sel  = is_rem ? rem[W-1:0] : quo;
    res_next = neg ? -res_sel : res_sel;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      is_rem  <= 1'b0;
      neg     <= 1'b0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      res_o   <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          busy_o <= 1'b1;
          is_rem <= op_i[1];
          dvs    <= mag_b;
          // special cases preload the final magnitudes and skip CALC
          if (div0) begin
            quo   <= '1;
            rem   <= {1'b0, a_i};
            neg   <= 1'b0;
            state <= DONE;
          end else if (ovf) begin
            quo   <= {1'b1, {(W-1){1'b0}}};
            rem   <= '0;
            neg   <= 1'b0;
            state <= DONE;
          end else begin
            quo   <= mag_a;
            rem   <= '0;
            neg   <= op_i[1] ? sa : sa ^ sb;
            cnt   <= CW'(W);
            state <= CALC;
          end
        end
        CALC: begin
          rem   <= trial[W+1] ? shifted : trial[W:0];
          quo   <= {quo[W-2:0], !trial[W+1]};
          cnt   <= cnt - 1'b1;
          state <= cnt == CW'(1) ? DONE : CALC;
        end
        DONE: begin
          res_o   <= res_next;
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, valid_o;
  logic [31:0] res_o;
  int          tests = 0;
  int          fails = 0;

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .valid_o(valid_o), .res_o(res_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0; op_i = ~op; a_i = ~a; b_i = b + 32'd1;
  endtask

  // returns edges from the accepting edge to the edge that raised valid_o
  task automatic wait_valid(input int poke, output int lat, output logic busy_ok);
    int n = 1;
    busy_ok = 1'b1;
    while (valid_o !== 1'b1 && n < 100) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      start_i = (n == poke);
      if (n == poke) begin op_i = 2'b01; a_i = 32'd77; b_i = 32'd0; end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    lat = n - 1;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic bok;
    start_op(op, a, b);
    wait_valid(0, lat, bok);
    check({tag, " res"}, res_o, exp_res);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_during"}, {31'd0, bok}, 32'd1);
    check({tag, " busy_at_valid"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check({tag, " valid_pulse"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic bok;
    int   seen;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset valid", {31'd0, valid_o}, 32'd0);
    check("reset res", res_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    do_op("rem -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    do_op("div -7/2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    do_op("remu -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 33);
    do_op("div ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    do_op("divu by0", 2'b01, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    do_op("remu by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 1);
    do_op("div by0", 2'b00, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1);
    do_op("rem by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
    do_op("div 0/5", 2'b00, 32'd0, 32'd5, 32'd0, 33);
    do_op("divu max/1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    do_op("div min/2", 2'b00, 32'h80000000, 32'd2, 32'hC0000000, 33);
    do_op("rem min/3", 2'b10, 32'h80000000, 32'd3, 32'hFFFFFFFE, 33);
    do_op("div 7/-2", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);

    start_op(2'b01, 32'd1000, 32'd10);
    wait_valid(5, lat, bok);
    check("ignored start res", res_o, 32'd100);
    check("ignored start latency", 32'(lat), 32'd33);
    check("ignored start busy", {31'd0, bok}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      a_i = a_i + 32'd3;
      if (valid_o) seen++;
    end
    check("ignored start extra valid", 32'(seen), 32'd0);
    check("res hold", res_o, 32'd100);

    start_op(2'b00, 32'd100, 32'd3);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_o}, 32'd0);
    check("abort valid", {31'd0, valid_o}, 32'd0);
    check("abort res", res_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    check("abort no valid", 32'(seen), 32'd0);
    do_op("div 9/3 after reset", 2'b00, 32'd9, 32'd3, 32'd3, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
